demux8t1_32_buf: RTL and testbench
==================================

# demux8t1_32_buf

Buffered 1-to-8 32-bit demultiplexer: routes a 32-bit word from one upstream source to one of eight downstream channels chosen by a 3-bit select. Each channel has a one-entry output buffer with a valid/ready handshake, so slow consumers can back-pressure the source without losing data. It is the write-side counterpart of the 8-to-1 32-bit read multiplexer. It sits between the MSOC bus master and up to eight peripheral or display sinks.

## Interface
- No parameters. Width is fixed at 32 bits and channel count at 8.
- `clk` — in, 1 — system clock, rising-edge.
- `rst_n` — in, 1 — reset, asynchronous and active-low.
- `s` — in, 3 — destination channel select (0–7); sampled with `i_valid`.
- `i_data` — in, 32 — word to deliver.
- `i_valid` — in, 1 — upstream has a word.
- `i_ready` — out, 1 — block accepts the word this cycle.
- `bcast` — in, 1 — broadcast request; honoured only when compiled in (see Configuration).
- `o_data` — out, 256 — channel k buffer is at bits [32k+31:32k].
- `o_valid` — out, 8 — bit k is set when channel k's buffer is full.
- `o_ready` — in, 8 — bit k is set when consumer k takes the word.
- `occ` — out, 4 — number of full channel buffers (0–8).

## Operation
- **State per channel k:** `full[k]` and `buf[k][31:0]`. `o_valid[k] = full[k]` and the `o_data` slice k = `buf[k]`, both driven directly from registers.
- **Reset** (`rst_n` = 0, takes effect immediately, no clock needed): all `full` = 0, all `buf` = 0, `occ` = 0. So `o_valid` = 8'h00 and `o_data` = 0.
- **Free slot:** `free[k] = !full[k] || o_ready[k]`. A slot being drained this cycle counts as free.
- **Unicast accept:**
  - `i_ready = free[s]`; this is combinational from `s`, `full` and `o_ready`.
  - A transfer happens when `i_valid && i_ready`. At the next edge, `buf[s]` ← `i_data` and `full[s]` ← 1.
- **Drain:** when `full[k] && o_ready[k]` and no refill of k occurs, `full[k]` ← 0 at the edge. `buf[k]` holds its old value.
- **Simultaneous drain and refill of the same channel:** `full[k]` stays 1 and `buf[k]` takes the new word. No bubble is inserted and nothing is lost.
- **Independent channels:** drains on any subset of channels happen in the same cycle as an accept on another channel.
- **Upstream protocol:** upstream must hold `i_data`, `s` and `bcast` stable while `i_valid` = 1 and `i_ready` = 0. The block does not check this.
- **`occ` register:** at every edge it loads the population count of the next-state `full` vector. It is never a stale or combinational value.
- **`o_ready[k]` with `full[k]` = 0:** ignored.

## Timing
- **Latency:** one cycle from accept to output. A word accepted at edge n appears on `o_valid` and `o_data` after edge n.
- **Throughput:** one word per cycle per source. A single channel sustains one word per cycle when its consumer holds `o_ready` = 1.
- **Combinational path:** `i_ready` depends on `o_ready` combinationally. All outputs other than `i_ready` are registered.
- **Reset mid-transfer:** an accept in the reset cycle is discarded. Buffered words are lost. `occ` returns to 0.

## Configuration
- **Macro:** `DEMUX8_BCAST_EN`.
- **With the macro defined:**
  - When `bcast` = 1, `i_ready` = AND of `free[0..7]`, and `s` is ignored.
  - An accepted word is written to all 8 buffers and sets all `full` bits, so `occ` becomes 8.
  - A channel being drained in the same cycle is refilled, as in the unicast case.
- **Without the macro:** `bcast` is left unconnected internally, and behaviour is as if `bcast` = 0.

## Test plan
- **Reset values:** assert `rst_n` = 0 between clock edges. Expect `o_valid` = 8'h00, `occ` = 0 and `o_data` = 0 immediately, with no edge required.
- **Unicast fill and stall:**
  - Send `s` = 3 with `i_data` = 32'hDEADBEEF and `o_ready` = 0. Expect `o_valid` = 8'h08, slice 3 = DEADBEEF and `occ` = 1.
  - Send a second word to `s` = 3 while `o_ready` = 0. Expect `i_ready` = 0 and the data unchanged.
- **Same-cycle drain and refill:**
  - Channel 5 holds 32'h1. Set `o_ready[5]` = 1 and send 32'h2 to `s` = 5.
  - Expect `i_ready` = 1, then slice 5 = 2, `o_valid[5]` still 1 and `occ` unchanged.
- **Parallel traffic:**
  - Fill channels 0 through 7 with values 0x10 through 0x17. Expect `occ` = 8.
  - Pulse `o_ready` = 8'hA5. Expect `o_valid` = 8'h5A and `occ` = 4.
- **Broadcast (macro on):**
  - With channel 2 full and `o_ready[2]` = 0, `bcast` = 1 gives `i_ready` = 0.
  - Raising `o_ready[2]` = 1 causes the word 32'hCAFE0000 to be accepted. Expect all slices = CAFE0000 and `occ` = 8.
  - With the macro off, the same stimulus writes only channel `s`.
- **Reset mid-operation:** with 3 channels full and an accept in flight, pulse `rst_n` low. Expect `occ` = 0, `o_valid` = 0, and no write landing after release.

Source files
------------

// File: rtl/demux8t1_32_buf.sv
// ============================================================================
// Module   : demux8t1_32_buf
// Brief    : Buffered 1-to-8 32-bit demultiplexer, one-entry valid/ready
//            buffer per channel. Define DEMUX8_BCAST_EN to enable broadcast.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux8t1_32_buf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   s,
  input  logic [31:0]  i_data,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic         bcast,
  output logic [255:0] o_data,
  output logic [7:0]   o_valid,
  input  logic [7:0]   o_ready,
  output logic [3:0]   occ
);

  localparam int c_NCH = 8;

  logic [c_NCH-1:0]       r_full;
  logic [c_NCH-1:0][31:0] r_buf;
  logic [3:0]             r_occ;

  logic [c_NCH-1:0] w_free;
  logic [c_NCH-1:0] w_wr;
  logic [c_NCH-1:0] w_full_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_bc;
  logic             w_acc;

`ifdef DEMUX8_BCAST_EN
  assign w_bc = bcast;
`else
  logic w_bcast_unused;
  assign w_bcast_unused = bcast;
  assign w_bc           = 1'b0;
`endif

  // A slot being drained this cycle can take a new word at the same edge.
  assign w_free  = ~r_full | o_ready;
  assign i_ready = w_bc ? (&w_free) : w_free[s];
  assign w_acc   = i_valid & i_ready;

  generate
    for (genvar k = 0; k < c_NCH; k++) begin : g_ch
      assign w_wr[k]       = w_acc & (w_bc | (s == 3'(k)));
      assign w_full_nxt[k] = w_wr[k] | (r_full[k] & ~o_ready[k]);
    end
  endgenerate

  always_comb begin
    w_cnt_nxt = 4'd0;
    for (int k = 0; k < c_NCH; k++) begin
      w_cnt_nxt = w_cnt_nxt + {3'd0, w_full_nxt[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_buf  <= '0;
      r_occ  <= 4'd0;
    end else begin
      r_full <= w_full_nxt;
      r_occ  <= w_cnt_nxt;
      for (int k = 0; k < c_NCH; k++) begin
        if (w_wr[k]) begin
          r_buf[k] <= i_data;
        end
      end
    end
  end

  assign o_valid = r_full;
  assign o_data  = r_buf;
  assign occ     = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_demux8t1_32_buf.sv
// ============================================================================
// Module   : tb_demux8t1_32_buf
// Brief    : Self-checking bench for demux8t1_32_buf with a per-channel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux8t1_32_buf;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [2:0]   s = 3'd0;
  logic [31:0]  i_data = 32'd0;
  logic         i_valid = 1'b0;
  logic         bcast = 1'b0;
  logic [7:0]   o_ready = 8'd0;
  logic         i_ready;
  logic [255:0] o_data;
  logic [7:0]   o_valid;
  logic [3:0]   occ;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_full [8];
  logic [31:0] m_buf  [8];

  demux8t1_32_buf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .bcast   (bcast),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  function automatic bit bc_on();
`ifdef DEMUX8_BCAST_EN
    return bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready();
    bit r;
    if (bc_on()) begin
      r = 1'b1;
      for (int k = 0; k < 8; k++) r = r && (!m_full[k] || o_ready[k]);
    end else begin
      r = !m_full[s] || o_ready[s];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_occ();
    int c = 0;
    for (int k = 0; k < 8; k++) c += int'(m_full[k]);
    return 4'(c);
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [255:0] exp_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = m_buf[k];
    return d;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_buf[k]  = 32'd0;
    end
  endtask

  // Advance one clock edge, updating the model from the inputs seen at it.
  task automatic tick();
    bit          acc;
    bit          nf [8];
    logic [31:0] nb [8];
    acc = i_valid && exp_ready();
    for (int k = 0; k < 8; k++) begin
      nf[k] = m_full[k];
      nb[k] = m_buf[k];
      if (acc && (bc_on() || s == 3'(k))) begin
        nf[k] = 1'b1;
        nb[k] = i_data;
      end else if (m_full[k] && o_ready[k]) begin
        nf[k] = 1'b0;
      end
    end
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      for (int k = 0; k < 8; k++) begin
        m_full[k] = nf[k];
        m_buf[k]  = nb[k];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    i_valid = 1'b0; bcast = 1'b0; o_ready = 8'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (o_valid !== 8'h00) begin n_bad++; $display("FAIL reset_valid got %h want 00", o_valid); end
    n_cmp++;
    if (occ !== 4'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_cmp++;
    if (o_data !== 256'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", o_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast_stall();
    s = 3'd3; i_data = 32'hDEADBEEF; i_valid = 1'b1; o_ready = 8'h00;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin n_bad++; $display("FAIL uni_ready got %b want 1", i_ready); end
    tick();
    n_cmp++;
    if (o_valid !== 8'h08) begin n_bad++; $display("FAIL uni_valid got %h want 08", o_valid); end
    n_cmp++;
    if (o_data[127:96] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL uni_data got %h want deadbeef", o_data[127:96]); end
    n_cmp++;
    if (occ !== 4'd1) begin n_bad++; $display("FAIL uni_occ got %0d want 1", occ); end
    i_data = 32'h12345678;
    #1;
    n_cmp++;
    if (i_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready got %b want 0", i_ready); end
    tick();
    n_cmp++;
    if (o_data[127:96] !== 32'hDEADBEEF || o_valid !== 8'h08) begin
      n_bad++; $display("FAIL stall_hold got %h/%h want deadbeef/08", o_data[127:96], o_valid);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_drain_refill();
    s = 3'd5; i_data = 32'h1; i_valid = 1'b1; o_ready = 8'h00;
    tick();
    i_data = 32'h2; o_ready = 8'h20;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin n_bad++; $display("FAIL refill_ready got %b want 1", i_ready); end
    tick();
    i_valid = 1'b0; o_ready = 8'h00;
    n_cmp++;
    if (o_data[191:160] !== 32'h2) begin n_bad++; $display("FAIL refill_data got %h want 2", o_data[191:160]); end
    n_cmp++;
    if (o_valid !== 8'h28) begin n_bad++; $display("FAIL refill_valid got %h want 28", o_valid); end
    n_cmp++;
    if (occ !== 4'd2) begin n_bad++; $display("FAIL refill_occ got %0d want 2", occ); end
  endtask

  task automatic test_parallel();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      s = 3'(k); i_data = 32'h10 + 32'(k); i_valid = 1'b1; o_ready = 8'h00;
      tick();
    end
    i_valid = 1'b0;
    n_cmp++;
    if (occ !== 4'd8) begin n_bad++; $display("FAIL par_occ8 got %0d want 8", occ); end
    n_cmp++;
    if (o_data[255:224] !== 32'h17 || o_data[31:0] !== 32'h10) begin
      n_bad++; $display("FAIL par_data got %h/%h want 17/10", o_data[255:224], o_data[31:0]);
    end
    o_ready = 8'hA5;
    tick();
    o_ready = 8'h00;
    n_cmp++;
    if (o_valid !== 8'h5A) begin n_bad++; $display("FAIL par_valid got %h want 5a", o_valid); end
    n_cmp++;
    if (occ !== 4'd4) begin n_bad++; $display("FAIL par_occ4 got %0d want 4", occ); end
  endtask

  task automatic test_bcast();
    do_reset();
    s = 3'd2; i_data = 32'h0000BEEF; i_valid = 1'b1;
    tick();
    bcast = 1'b1; i_data = 32'hCAFE0000; o_ready = 8'h00;
    #1;
    n_cmp++;
    if (i_ready !== 1'b0) begin n_bad++; $display("FAIL bc_block got %b want 0", i_ready); end
    o_ready = 8'h04;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin n_bad++; $display("FAIL bc_ready got %b want 1", i_ready); end
    tick();
    i_valid = 1'b0; bcast = 1'b0; o_ready = 8'h00;
`ifdef DEMUX8_BCAST_EN
    n_cmp++;
    if (o_data !== {8{32'hCAFE0000}}) begin n_bad++; $display("FAIL bc_data got %h want all cafe0000", o_data); end
    n_cmp++;
    if (occ !== 4'd8 || o_valid !== 8'hFF) begin n_bad++; $display("FAIL bc_occ got %0d/%h want 8/ff", occ, o_valid); end
`else
    n_cmp++;
    if (o_data !== {160'd0, 32'hCAFE0000, 64'd0}) begin n_bad++; $display("FAIL bc_data got %h want only ch2", o_data); end
    n_cmp++;
    if (occ !== 4'd1 || o_valid !== 8'h04) begin n_bad++; $display("FAIL bc_occ got %0d/%h want 1/04", occ, o_valid); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    s = 3'd6; o_ready = 8'h40; i_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      i_data = 32'hA000_0000 + 32'(n);
      #1;
      n_cmp++;
      if (i_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", n, i_ready); end
      tick();
      n_cmp++;
      if (o_data[223:192] !== 32'hA000_0000 + 32'(n) || o_valid !== 8'h40) begin
        n_bad++; $display("FAIL b2b_word[%0d] got %h/%h want %h/40", n, o_data[223:192], o_valid, 32'hA000_0000 + 32'(n));
      end
    end
    i_valid = 1'b0; o_ready = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      s = 3'(k); i_data = 32'h55 + 32'(k); i_valid = 1'b1;
      tick();
    end
    s = 3'd4; i_data = 32'h99; i_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (occ !== 4'd0 || o_valid !== 8'h00) begin n_bad++; $display("FAIL mid_rst got %0d/%h want 0/00", occ, o_valid); end
    tick();
    i_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (occ !== 4'd0 || o_valid !== 8'h00 || o_data !== 256'd0) begin
      n_bad++; $display("FAIL mid_release got %0d/%h data %h want 0/00/0", occ, o_valid, o_data);
    end
  endtask

  task automatic test_random();
    bit stalled = 1'b0;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if (!stalled) begin
        s       = 3'($urandom_range(0, 7));
        i_data  = $urandom;
        i_valid = ($urandom_range(0, 3) != 0);
        bcast   = ($urandom_range(0, 5) == 0);
      end
      o_ready = 8'($urandom);
      #1;
      n_cmp++;
      if (i_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b want %b", n, i_ready, exp_ready()); end
      stalled = i_valid && !exp_ready();
      tick();
      n_cmp++;
      if (o_valid !== exp_valid() || occ !== exp_occ()) begin
        n_bad++; $display("FAIL rnd_state[%0d] got %h/%0d want %h/%0d", n, o_valid, occ, exp_valid(), exp_occ());
      end
      n_cmp++;
      if (o_data !== exp_data()) begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", n, o_data, exp_data()); end
    end
    i_valid = 1'b0; bcast = 1'b0; o_ready = 8'h00;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_unicast_stall();
    test_drain_refill();
    test_parallel();
    test_bcast();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
